wb_writer: RTL and testbench
============================

// Module: wb_writer
// PURPOSE
//  Write-back controller: the writer side of the register file write port (rg_wrt_en/dest/data).
//  Merges two result sources into at most one register write per cycle:
//   - ALU results, buffered in a small FIFO.
//   - Load results from data memory, using a valid/ready handshake.
//  Formats load data per funct3/byte offset, suppresses writes to x0, and bounds ALU starvation.
// PARAMETERS
//  DATA_WIDTH     32  register/data width (formatting logic requires 32)
//  ADDRESS_WIDTH  5   register index width
//  FIFO_DEPTH     4   ALU result FIFO entries (power of 2, >=2)
//  MAX_WAIT       3   max consecutive cycles a non-empty ALU FIFO may lose to loads
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous reset, active-high
//  alu_valid     in   1   ALU result present
//  alu_ready     out  1   FIFO can accept (count < FIFO_DEPTH)
//  alu_dest      in   ADDRESS_WIDTH  ALU destination register
//  alu_data      in   DATA_WIDTH     ALU result
//  ld_valid      in   1   load data present
//  ld_ready      out  1   load accepted this cycle
//  ld_dest       in   ADDRESS_WIDTH  load destination register
//  ld_funct3     in   3   load type
//  ld_byte_off   in   2   address[1:0] of the load
//  ld_rdata      in   DATA_WIDTH     raw 32-bit memory word
//  rg_wrt_en     out  1   register file write enable (registered)
//  rg_wrt_dest   out  ADDRESS_WIDTH  write address (registered)
//  rg_wrt_data   out  DATA_WIDTH     write data (registered)
//  busy          out  1   FIFO non-empty or rg_wrt_en high
// BEHAVIOUR
//  - Reset (rst=1 at posedge): FIFO emptied, wait counter=0, rg_wrt_en/dest/data=0.
//    Buffered entries are discarded mid-operation. alu_ready and ld_ready are held 0 while rst=1.
//  - ALU push: alu_valid && alu_ready at an edge enqueues {dest,data}.
//    alu_ready depends on count only: when full, a push is refused even if a pop occurs that cycle.
//  - Per-cycle arbitration between FIFO head (hv = FIFO non-empty) and the load:
//    - starve = hv && wait==MAX_WAIT; ld_ready = !starve.
//    - Load wins when ld_valid && !starve; otherwise the FIFO head pops if hv.
//  - Wait counter:
//    - +1 on edges where hv is set and a load wins.
//    - Cleared on a FIFO pop or when FIFO is empty.
//    - Saturates at MAX_WAIT.
//  - Output register, loaded at each edge from the selected source:
//    - rg_wrt_en = (source selected) && dest!=0.
//    - dest/data are loaded even when en=0.
//    - No source selected: rg_wrt_en=0; dest/data hold.
//    - A dest=0 entry is consumed without any write.
//  - Latency:
//    - Load: handshake at edge e -> rg_wrt_en high after e (1 cycle).
//    - ALU into empty FIFO with no load: enqueued at e, written after e+1 (2 cycles).
//  - Simultaneous push and pop in the same cycle are both performed; count is unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; FIFO order is strict.
//  - Load formatting (b = byte at off; h = half at off[1], off[0] ignored):
//    - 000 LB: sext(b)
//    - 001 LH: sext(h)
//    - 010 LW: word, off ignored
//    - 100 LBU: zext(b)
//    - 101 LHU: zext(h)
//    - 011/110/111: treated as LW
// TESTING
//  1. Reset mid-stream, FIFO holding 3 entries -> rg_wrt_en=0 next cycle, busy=0; no entry ever written.
//  2. ALU {dest=5, data=0xDEADBEEF} alone -> rg_wrt_en=1, dest=5, data=0xDEADBEEF exactly 2 cycles later.
//  3. Load ld_rdata=0x80FF7F01: LB off=2 -> 0xFFFFFFFF; LBU off=3 -> 0x00000080; LH off=1 -> 0x00007F01; LHU off=2 -> 0x000080FF; funct3=111 -> 0x80FF7F01.
//  4. ld_valid held high, one ALU entry queued, MAX_WAIT=3 -> 3 load writes, then ld_ready=0 for 1 cycle and the ALU entry is written, then loads resume.
//  5. Push 4 ALU results while loads win -> alu_ready=0 at count=4; 5th refused; order 1..4 preserved on write.
//  6. ALU dest=0 and load dest=0 -> both consumed, rg_wrt_en stays 0, FIFO count decrements.

Source files
------------

// File: rtl/wb_writer_if.sv
// Write-back port bundle: ALU result stream, load result stream and the
// register-file write port with the busy flag.
interface wb_writer_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5
);
   logic                     alu_valid;
   logic                     alu_ready;
   logic [ADDRESS_WIDTH-1:0] alu_dest;
   logic [DATA_WIDTH-1:0]    alu_data;
   logic                     ld_valid;
   logic                     ld_ready;
   logic [ADDRESS_WIDTH-1:0] ld_dest;
   logic [2:0]               ld_funct3;
   logic [1:0]               ld_byte_off;
   logic [DATA_WIDTH-1:0]    ld_rdata;
   logic                     rg_wrt_en;
   logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
   logic [DATA_WIDTH-1:0]    rg_wrt_data;
   logic                     busy;

   modport slave (
      input  alu_valid, alu_dest, alu_data,
      input  ld_valid, ld_dest, ld_funct3, ld_byte_off, ld_rdata,
      output alu_ready, ld_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data, busy
   );

   modport master (
      output alu_valid, alu_dest, alu_data,
      output ld_valid, ld_dest, ld_funct3, ld_byte_off, ld_rdata,
      input  alu_ready, ld_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data, busy
   );
endinterface

// File: rtl/wb_writer.sv
// Write-back controller: merges buffered ALU results and handshaked load
// results into one registered register-file write per cycle.
module wb_writer #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned MAX_WAIT      = 3
) (
   input logic        clk,
   input logic        rst,
   wb_writer_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   logic [ADDRESS_WIDTH-1:0] r_fifo_dest [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]         r_wptr;
   logic [PTR_W-1:0]         r_rptr;
   logic [PTR_W:0]           r_count;
   logic [WAIT_W-1:0]        r_wait;
   logic                     r_wrt_en;
   logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
   logic [DATA_WIDTH-1:0]    r_wrt_data;

   logic                     w_hv;
   logic                     w_starve;
   logic                     w_ld_win;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_alu_ready;
   logic [DATA_WIDTH-1:0]    w_ld_fmt;

   function automatic logic [31:0] f_fmt(input logic [2:0]  f3,
                                         input logic [1:0]  off,
                                         input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  f_fmt = {{24{b[7]}}, b};
         3'b001:  f_fmt = {{16{h[15]}}, h};
         3'b100:  f_fmt = {24'd0, b};
         3'b101:  f_fmt = {16'd0, h};
         default: f_fmt = word;
      endcase
   endfunction

   assign w_hv        = (r_count != '0);
   assign w_starve    = w_hv && (r_wait == WAIT_W'(MAX_WAIT));
   assign w_ld_win    = bus.ld_valid && !w_starve;
   assign w_pop       = w_hv && !w_ld_win;
   // Readiness looks at count only, so a full FIFO refuses even while popping.
   assign w_alu_ready = !rst && (r_count < (PTR_W+1)'(FIFO_DEPTH));
   assign w_push      = bus.alu_valid && w_alu_ready;
   assign w_ld_fmt    = f_fmt(bus.ld_funct3, bus.ld_byte_off, bus.ld_rdata);

   assign bus.alu_ready   = w_alu_ready;
   assign bus.ld_ready    = !rst && !w_starve;
   assign bus.rg_wrt_en   = r_wrt_en;
   assign bus.rg_wrt_dest = r_wrt_dest;
   assign bus.rg_wrt_data = r_wrt_data;
   assign bus.busy        = w_hv || r_wrt_en;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_dest[r_wptr] <= bus.alu_dest;
         r_fifo_data[r_wptr] <= bus.alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_wait     <= '0;
         r_wrt_en   <= 1'b0;
         r_wrt_dest <= '0;
         r_wrt_data <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase

         if (!w_hv || w_pop)                     r_wait <= '0;
         else if (r_wait != WAIT_W'(MAX_WAIT))   r_wait <= r_wait + WAIT_W'(1);

         if (w_ld_win) begin
            r_wrt_en   <= (bus.ld_dest != '0);
            r_wrt_dest <= bus.ld_dest;
            r_wrt_data <= w_ld_fmt;
         end else if (w_pop) begin
            r_wrt_en   <= (r_fifo_dest[r_rptr] != '0);
            r_wrt_dest <= r_fifo_dest[r_rptr];
            r_wrt_data <= r_fifo_data[r_rptr];
         end else begin
            r_wrt_en   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_writer;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_writer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();

   wb_writer #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] m_fmt(int unsigned f3, int unsigned off, logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         4:       return b;
         5:       return h;
         default: return w;
      endcase
   endfunction

   // Reference model: FIFO as a queue, starvation as an integer counter.
   typedef struct packed {
      logic [AW-1:0] d;
      logic [DW-1:0] v;
   } ent_t;

   ent_t          mq[$];
   int            m_wait = 0;
   logic          m_en   = 1'b0;
   logic [AW-1:0] m_dest = '0;
   logic [DW-1:0] m_data = '0;
   bit            m_ok   = 1'b0;

   always @(posedge clk) begin
      bit   hv, starve, ldwin, pop, push;
      ent_t h;
      if (rst) begin
         mq.delete();
         m_wait = 0;
         m_en   = 1'b0;
         m_dest = '0;
         m_data = '0;
      end else begin
         hv     = (mq.size() != 0);
         starve = hv && (m_wait == MW);
         ldwin  = bus.ld_valid && !starve;
         pop    = hv && !ldwin;
         push   = bus.alu_valid && (mq.size() < DEPTH);
         if (ldwin) begin
            m_dest = bus.ld_dest;
            m_data = m_fmt(bus.ld_funct3, bus.ld_byte_off, bus.ld_rdata);
            m_en   = (bus.ld_dest != 0);
         end else if (pop) begin
            h      = mq[0];
            m_dest = h.d;
            m_data = h.v;
            m_en   = (h.d != 0);
         end else begin
            m_en = 1'b0;
         end
         if (!hv || pop)      m_wait = 0;
         else if (m_wait < MW) m_wait++;
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back({bus.alu_dest, bus.alu_data});
      end
      m_ok = 1'b1;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("rg_wrt_en",   32'(bus.rg_wrt_en),   32'(m_en));
         chk("rg_wrt_dest", 32'(bus.rg_wrt_dest), 32'(m_dest));
         chk("rg_wrt_data", bus.rg_wrt_data,      m_data);
         chk("busy",        32'(bus.busy),        32'((mq.size() != 0) || m_en));
         chk("alu_ready",   32'(bus.alu_ready),   32'(!rst && (mq.size() < DEPTH)));
         chk("ld_ready",    32'(bus.ld_ready),
             32'(!rst && !((mq.size() != 0) && (m_wait == MW))));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid   = 1'b0;
      bus.alu_dest    = '0;
      bus.alu_data    = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_dest     = '0;
      bus.ld_funct3   = '0;
      bus.ld_byte_off = '0;
      bus.ld_rdata    = '0;
   endtask

   int unsigned t3_f3  [5] = '{0, 4, 1, 5, 7};
   int unsigned t3_off [5] = '{2, 3, 1, 2, 0};
   logic [31:0] t3_exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01,
                               32'h0000_80FF, 32'h80FF_7F01};

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_en",   32'(bus.rg_wrt_en), 32'd0);
      chk("reset_busy", 32'(bus.busy),      32'd0);

      // Lone ALU result: written two edges after being presented.
      tick();
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 5'd5;
      bus.alu_data  = 32'hDEAD_BEEF;
      tick();
      bus.alu_valid = 1'b0;
      @(negedge clk);
      chk("alu_lat_early", 32'(bus.rg_wrt_en), 32'd0);
      tick();
      @(negedge clk);
      chk("alu_lat_en",   32'(bus.rg_wrt_en),   32'd1);
      chk("alu_lat_dest", 32'(bus.rg_wrt_dest), 32'd5);
      chk("alu_lat_data", bus.rg_wrt_data,      32'hDEAD_BEEF);

      // Load formatting, one-cycle latency.
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.ld_valid    = 1'b1;
         bus.ld_dest     = AW'(i + 1);
         bus.ld_funct3   = 3'(t3_f3[i]);
         bus.ld_byte_off = 2'(t3_off[i]);
         bus.ld_rdata    = 32'h80FF_7F01;
         tick();
         bus.ld_valid = 1'b0;
         @(negedge clk);
         chk("ld_fmt_en",   32'(bus.rg_wrt_en), 32'd1);
         chk("ld_fmt_data", bus.rg_wrt_data,    t3_exp[i]);
      end

      // Starvation bound with loads held valid.
      tick();
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 5'd9;
      bus.alu_data  = 32'h0000_1234;
      bus.ld_valid  = 1'b1;
      bus.ld_dest   = 5'd7;
      bus.ld_funct3 = 3'b010;
      bus.ld_rdata  = 32'hCAFE_0001;
      tick();
      bus.alu_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("starve_ld_ready", 32'(bus.ld_ready),    (k == 3) ? 32'd0 : 32'd1);
         chk("starve_ld_dest",  32'(bus.rg_wrt_dest), 32'd7);
         tick();
      end
      @(negedge clk);
      chk("starve_alu_dest", 32'(bus.rg_wrt_dest), 32'd9);
      chk("starve_alu_data", bus.rg_wrt_data,      32'h0000_1234);
      chk("starve_resume",   32'(bus.ld_ready),    32'd1);
      tick();
      @(negedge clk);
      chk("starve_ld_again", 32'(bus.rg_wrt_dest), 32'd7);
      idle_inputs();
      repeat (3) tick();

      // Fill to full while loads win; fifth push refused; order kept.
      bus.ld_valid = 1'b1;
      bus.ld_dest  = 5'd3;
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_dest  = AW'(11 + i);
         bus.alu_data  = 32'(i + 1);
         tick();
      end
      bus.alu_dest = 5'd15;
      bus.alu_data = 32'd5;
      bus.ld_valid = 1'b0;
      @(negedge clk);
      chk("full_alu_ready", 32'(bus.alu_ready), 32'd0);
      tick();
      bus.alu_valid = 1'b0;
      @(negedge clk);
      chk("order_dest", 32'(bus.rg_wrt_dest), 32'd11);
      for (int j = 1; j < 4; j++) begin
         tick();
         @(negedge clk);
         chk("order_dest", 32'(bus.rg_wrt_dest), 32'(11 + j));
         chk("order_data", bus.rg_wrt_data,      32'(j + 1));
      end
      tick();
      @(negedge clk);
      chk("refused_no_write", 32'(bus.rg_wrt_en), 32'd0);
      idle_inputs();
      repeat (2) tick();

      // x0 destinations are consumed silently.
      bus.alu_valid = 1'b1;
      bus.alu_dest  = '0;
      bus.alu_data  = 32'h0000_ABCD;
      bus.ld_valid  = 1'b1;
      bus.ld_dest   = '0;
      tick();
      idle_inputs();
      @(negedge clk);
      chk("x0_ld_en",   32'(bus.rg_wrt_en), 32'd0);
      chk("x0_busy",    32'(bus.busy),      32'd1);
      tick();
      @(negedge clk);
      chk("x0_alu_en",  32'(bus.rg_wrt_en), 32'd0);
      chk("x0_drained", 32'(bus.busy),      32'd0);

      // Reset with three buffered entries discards them.
      bus.ld_valid = 1'b1;
      bus.ld_dest  = 5'd3;
      for (int i = 0; i < 3; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_dest  = AW'(20 + i);
         bus.alu_data  = 32'(100 + i);
         tick();
      end
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_en",   32'(bus.rg_wrt_en), 32'd0);
      chk("midrst_busy", 32'(bus.busy),      32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         chk("midrst_no_write", 32'(bus.rg_wrt_en), 32'd0);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst             = ($urandom_range(0, 63) == 0);
         bus.alu_valid   = ($urandom_range(0, 99) < 55);
         bus.alu_dest    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         bus.alu_data    = $urandom;
         bus.ld_valid    = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 40 : 85));
         bus.ld_dest     = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         bus.ld_funct3   = 3'($urandom);
         bus.ld_byte_off = 2'($urandom);
         bus.ld_rdata    = $urandom;
      end
      rst = 1'b0;
      idle_inputs();
      repeat (8) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
